// File: rtl/fetch_sequencer_16bit.sv
// Instruction fetch sequencer: owns the PC, issues one-at-a-time imem requests,
// hands fetched words to decode, and handles redirect, halt and timeout fault.
module fetch_sequencer_16bit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = 16'h0000,
    parameter int unsigned          PC_STEP  = 1,
    parameter int unsigned          MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               decode_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic [ADDR_W-1:0]  PC,
    output logic               fetch_fault
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        VALID  = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               kill_q, kill_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            target_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            wait_cnt_q <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            wait_cnt_q <= wait_cnt_d;
            kill_q     <= kill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        wait_cnt_d = wait_cnt_q;
        kill_d     = kill_q;

        unique case (state_q)
            IDLE: begin
                state_d = halt ? HALTED : FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    wait_cnt_d = '0;
                    if (kill_q || redirect) begin
                        // Stale word: drop it and refetch from the newest target
                        pc_d   = redirect ? redirect_pc : target_q;
                        kill_d = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + ADDR_W'(PC_STEP);
                        state_d    = VALID;
                    end
                end else begin
                    if (redirect) begin
                        target_d = redirect_pc;
                        kill_d   = 1'b1;
                    end
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        state_d = FAULT;
                    end
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (decode_ready) begin
                    state_d = halt ? HALTED : FETCH;
                end else if (redirect) begin
                    state_d = FETCH;
                end
            end
            HALTED: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (!halt) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // Moore outputs decoded from registered state only
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == VALID);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign PC          = pc_q;
    assign fetch_fault = (state_q == FAULT);

endmodule
